exa_crosb_output_vc_arbiter: RTL and testbench

EXA_CROSB_OUTPUT_VC_ARBITER -- requirements
Module: exa_crosb_output_vc_arbiter

---
 rtl/exa_crosb_output_vc_arbiter_if.sv | 34 +++
 rtl/exa_crosb_output_vc_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_exa_crosb_output_vc_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exa_crosb_output_vc_arbiter_if.sv
// Request/flit handshake between the crossbar input ports and one output VC arbiter.
interface exa_crosb_output_vc_arbiter_if #(
    parameter int unsigned input_num = 4,
    parameter int unsigned prio_num  = 2,
    parameter int unsigned vc_num    = 2
);
    localparam int unsigned NumVc     = prio_num * vc_num;
    localparam int unsigned logVcPrio = (NumVc > 1) ? $clog2(NumVc) : 1;

    logic [input_num-1:0]                i_req;
    logic [input_num-1:0][logVcPrio-1:0] i_req_vc;
    logic [input_num-1:0]                i_flit_valid;
    logic [input_num-1:0]                i_flit_last;
    logic [input_num-1:0]                o_grant;
    logic [input_num-1:0]                o_flit_accept;

    modport master (
        output i_req,
        output i_req_vc,
        output i_flit_valid,
        output i_flit_last,
        input  o_grant,
        input  o_flit_accept
    );

    modport slave (
        input  i_req,
        input  i_req_vc,
        input  i_flit_valid,
        input  i_flit_last,
        output o_grant,
        output o_flit_accept
    );
endinterface

// File: rtl/exa_crosb_output_vc_arbiter.sv
// Output-port VC arbiter: per-VC round-robin ownership with optional credit flow control.
// Define EXA_CROSB_VC_CREDIT_EN to build the per-VC credit counters and o_credit_err.
module exa_crosb_output_vc_arbiter #(
    parameter int unsigned input_num = 4,
    parameter int unsigned prio_num  = 2,
    parameter int unsigned vc_num    = 2,
    parameter int unsigned CREDITS   = 8,
    localparam int unsigned NumVc     = prio_num * vc_num,
    localparam int unsigned logIn     = (input_num > 1) ? $clog2(input_num) : 1,
    localparam int unsigned logVcPrio = (NumVc > 1) ? $clog2(NumVc) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    exa_crosb_output_vc_arbiter_if.slave  bus,
    input  logic [NumVc-1:0]              i_credit_ret,
    output logic [NumVc-1:0]              o_vc_busy,
    output logic [NumVc-1:0][logIn-1:0]   o_vc_owner,
    output logic                          o_credit_err
);

    typedef enum logic {StIdle, StActive} vc_state_e;

    vc_state_e                           r_state [NumVc];
    vc_state_e                           w_state_nxt [NumVc];
    logic [input_num-1:0]                r_grant;
    logic [input_num-1:0]                w_grant_nxt;
    logic [input_num-1:0][logVcPrio-1:0] r_in_vc;
    logic [input_num-1:0][logVcPrio-1:0] w_in_vc_nxt;
    logic [NumVc-1:0][logIn-1:0]         r_owner;
    logic [NumVc-1:0][logIn-1:0]         w_owner_nxt;
    logic [NumVc-1:0][logIn-1:0]         r_ptr;
    logic [NumVc-1:0][logIn-1:0]         w_ptr_nxt;

    logic [NumVc-1:0]                    w_credit_ok;
    logic [input_num-1:0]                w_accept;
    logic [NumVc-1:0]                    w_vc_acc;
    logic [NumVc-1:0]                    w_vc_tail;
    logic [NumVc-1:0]                    w_win_vld;
    logic [NumVc-1:0][logIn-1:0]         w_win;

    // Only an owner can present flits, so its remembered VC selects the credit gate.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < int'(input_num); i++) begin
            w_accept[i] = r_grant[i] & bus.i_flit_valid[i] & w_credit_ok[r_in_vc[i]];
        end
    end

    always_comb begin
        w_vc_acc  = '0;
        w_vc_tail = '0;
        for (int v = 0; v < int'(NumVc); v++) begin
            w_vc_acc[v]  = (r_state[v] == StActive) & w_accept[r_owner[v]];
            w_vc_tail[v] = w_vc_acc[v] & bus.i_flit_last[r_owner[v]];
        end
    end

    // Round-robin search from each idle VC's pointer over ungranted requesters.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_win_vld = '0;
        w_win     = '0;
        for (int v = 0; v < int'(NumVc); v++) begin
            if (r_state[v] == StIdle) begin
                for (int k = 0; k < int'(input_num); k++) begin
                    idx = (int'(r_ptr[v]) + k) % input_num;
                    if (!w_win_vld[v] && bus.i_req[idx] && !r_grant[idx] &&
                        (bus.i_req_vc[idx] == logVcPrio'(v))) begin
                        w_win_vld[v] = 1'b1;
                        w_win[v]     = logIn'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int v = 0; v < int'(NumVc); v++) begin
            w_state_nxt[v] = r_state[v];
            unique case (r_state[v])
                StIdle:   if (w_win_vld[v]) w_state_nxt[v] = StActive;
                StActive: if (w_vc_tail[v]) w_state_nxt[v] = StIdle;
                default:  w_state_nxt[v] = StIdle;
            endcase
        end
    end

    always_comb begin
        w_grant_nxt = r_grant;
        w_in_vc_nxt = r_in_vc;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        for (int i = 0; i < int'(input_num); i++) begin
            if (w_accept[i] && bus.i_flit_last[i]) begin
                w_grant_nxt[i] = 1'b0;
            end
        end
        for (int v = 0; v < int'(NumVc); v++) begin
            if (w_win_vld[v]) begin
                w_grant_nxt[w_win[v]] = 1'b1;
                w_in_vc_nxt[w_win[v]] = logVcPrio'(v);
                w_owner_nxt[v]        = w_win[v];
                w_ptr_nxt[v]          = (w_win[v] == logIn'(input_num - 1)) ? '0
                                                                         : w_win[v] + logIn'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_in_vc <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            for (int v = 0; v < int'(NumVc); v++) begin
                r_state[v] <= StIdle;
            end
        end else begin
            r_grant <= w_grant_nxt;
            r_in_vc <= w_in_vc_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            for (int v = 0; v < int'(NumVc); v++) begin
                r_state[v] <= w_state_nxt[v];
            end
        end
    end

`ifdef EXA_CROSB_VC_CREDIT_EN
    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic [CW-1:0] r_credit [NumVc];
    logic [CW-1:0] w_credit_nxt [NumVc];
    logic          r_credit_err;
    logic          w_credit_err_nxt;

    always_comb begin
        for (int v = 0; v < int'(NumVc); v++) begin
            w_credit_ok[v] = (r_credit[v] != '0);
        end
    end

    // A simultaneous accept and return cancel; a return into a full counter is an error.
    always_comb begin
        w_credit_err_nxt = r_credit_err;
        for (int v = 0; v < int'(NumVc); v++) begin
            w_credit_nxt[v] = r_credit[v];
            if (w_vc_acc[v] && !i_credit_ret[v]) begin
                w_credit_nxt[v] = r_credit[v] - CW'(1);
            end else if (!w_vc_acc[v] && i_credit_ret[v]) begin
                if (r_credit[v] == CW'(CREDITS)) begin
                    w_credit_err_nxt = 1'b1;
                end else begin
                    w_credit_nxt[v] = r_credit[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_err <= 1'b0;
            for (int v = 0; v < int'(NumVc); v++) begin
                r_credit[v] <= CW'(CREDITS);
            end
        end else begin
            r_credit_err <= w_credit_err_nxt;
            for (int v = 0; v < int'(NumVc); v++) begin
                r_credit[v] <= w_credit_nxt[v];
            end
        end
    end

    assign o_credit_err = r_credit_err;
`else
    logic w_unused_credit;

    assign w_credit_ok     = '1;
    assign o_credit_err    = 1'b0;
    assign w_unused_credit = ^{i_credit_ret, 1'(CREDITS)};
`endif

    always_comb begin
        o_vc_busy = '0;
        for (int v = 0; v < int'(NumVc); v++) begin
            o_vc_busy[v] = (r_state[v] == StActive);
        end
    end

    assign o_vc_owner        = r_owner;
    assign bus.o_grant       = r_grant;
    assign bus.o_flit_accept = w_accept;

endmodule

// File: tb/tb_exa_crosb_output_vc_arbiter.sv
// Directed bench for exa_crosb_output_vc_arbiter (default 4 inputs, 4 VCs, 8 credits).
module tb_exa_crosb_output_vc_arbiter;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      credit_ret;
    logic [3:0]      vc_busy;
    logic [3:0][1:0] vc_owner;
    logic            credit_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    exa_crosb_output_vc_arbiter_if #(
        .input_num(4),
        .prio_num (2),
        .vc_num   (2)
    ) u_bus ();

    exa_crosb_output_vc_arbiter #(
        .input_num(4),
        .prio_num (2),
        .vc_num   (2),
        .CREDITS  (8)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (u_bus),
        .i_credit_ret (credit_ret),
        .o_vc_busy    (vc_busy),
        .o_vc_owner   (vc_owner),
        .o_credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_flits();
        u_bus.i_flit_valid = '0;
        u_bus.i_flit_last  = '0;
    endtask

    task automatic req(input int i, input int vc);
        u_bus.i_req[i]    = 1'b1;
        u_bus.i_req_vc[i] = 2'(vc);
    endtask

    task automatic flit(input int i, input logic last);
        u_bus.i_flit_valid[i] = 1'b1;
        u_bus.i_flit_last[i]  = last;
    endtask

    initial begin
        u_bus.i_req    = '0;
        u_bus.i_req_vc = '0;
        clr_flits();
        credit_ret = '0;
        reset      = 1'b1;
        step();
        step();
        chk("rst_grant", 32'(u_bus.o_grant), 32'h0);
        chk("rst_busy", 32'(vc_busy), 32'h0);
        chk("rst_owner", 32'(vc_owner), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);
        reset = 1'b0;

        // Two inputs contend for VC1; pointer 0 favours input 0.
        req(0, 1);
        req(2, 1);
        step();
        chk("t1_grant", 32'(u_bus.o_grant), 32'b0001);
        chk("t1_busy", 32'(vc_busy), 32'b0010);
        chk("t1_owner", 32'(vc_owner[1]), 32'd0);
        u_bus.i_req[0] = 1'b0;
        flit(0, 1'b1);
        settle();
        chk("t1_acc", 32'(u_bus.o_flit_accept), 32'b0001);
        step();
        clr_flits();
        chk("t1_rel_grant", 32'(u_bus.o_grant), 32'h0);
        chk("t1_rel_busy", 32'(vc_busy), 32'h0);
        step();
        chk("t1_regrant", 32'(u_bus.o_grant), 32'b0100);
        chk("t1_owner2", 32'(vc_owner[1]), 32'd2);
        u_bus.i_req[2] = 1'b0;
        flit(2, 1'b1);
        settle();
        chk("t1_acc2", 32'(u_bus.o_flit_accept), 32'b0100);
        step();
        clr_flits();
        chk("t1_rel2", 32'(u_bus.o_grant), 32'h0);

        // VC1 pointer now sits at 3, so input 3 beats input 0.
        req(0, 1);
        req(3, 1);
        step();
        chk("t2_rr", 32'(u_bus.o_grant), 32'b1000);
        chk("t2_owner", 32'(vc_owner[1]), 32'd3);
        u_bus.i_req[3] = 1'b0;
        flit(3, 1'b1);
        step();
        clr_flits();
        chk("t2_gap", 32'(u_bus.o_grant), 32'h0);
        step();
        chk("t2_next", 32'(u_bus.o_grant), 32'b0001);
        u_bus.i_req[0] = 1'b0;
        flit(0, 1'b1);
        step();
        clr_flits();

        // Independent VCs, ignored requests to busy VCs, ungranted flits ignored.
        req(1, 0);
        req(3, 3);
        step();
        chk("t3_grant", 32'(u_bus.o_grant), 32'b1010);
        chk("t3_busy", 32'(vc_busy), 32'b1001);
        chk("t3_owner0", 32'(vc_owner[0]), 32'd1);
        chk("t3_owner3", 32'(vc_owner[3]), 32'd3);
        u_bus.i_req[1] = 1'b0;
        u_bus.i_req[3] = 1'b0;
        flit(1, 1'b0);
        req(0, 0);
        req(2, 3);
        u_bus.i_flit_valid[2] = 1'b1;
        settle();
        chk("t3_acc", 32'(u_bus.o_flit_accept), 32'b0010);
        step();
        chk("t3_hold", 32'(u_bus.o_grant), 32'b1010);
        u_bus.i_req[2] = 1'b0;
        clr_flits();
        flit(1, 1'b1);
        flit(3, 1'b1);
        settle();
        chk("t3_tails", 32'(u_bus.o_flit_accept), 32'b1010);
        step();
        clr_flits();
        chk("t3_rel", 32'(u_bus.o_grant), 32'h0);
        step();
        chk("t3_wait_grant", 32'(u_bus.o_grant), 32'b0001);
        chk("t3_wait_busy", 32'(vc_busy), 32'b0001);
        u_bus.i_req[0] = 1'b0;
        flit(0, 1'b1);
        step();
        clr_flits();

        // Long packet on fresh VC2.
        req(0, 2);
        step();
        chk("t4_grant", 32'(u_bus.o_grant), 32'b0001);
        u_bus.i_req[0] = 1'b0;
`ifdef EXA_CROSB_VC_CREDIT_EN
        for (int k = 0; k < 8; k++) begin
            flit(0, 1'b0);
            settle();
            chk("t4_acc", 32'(u_bus.o_flit_accept), 32'b0001);
            step();
        end
        chk("t4_block", 32'(u_bus.o_flit_accept), 32'h0);
        credit_ret[2] = 1'b1;
        step();
        credit_ret[2] = 1'b0;
        settle();
        chk("t4_resume", 32'(u_bus.o_flit_accept), 32'b0001);
        step();
        clr_flits();
        credit_ret[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
        end
        flit(0, 1'b0);
        settle();
        chk("t5_both", 32'(u_bus.o_flit_accept), 32'b0001);
        step();
        clr_flits();
        for (int k = 0; k < 3; k++) begin
            step();
        end
        chk("t5_noerr", 32'(credit_err), 32'h0);
        step();
        chk("t5_err", 32'(credit_err), 32'h1);
        credit_ret[2] = 1'b0;
        step();
        step();
        chk("t5_sticky", 32'(credit_err), 32'h1);
`else
        for (int k = 0; k < 20; k++) begin
            flit(0, 1'b0);
            credit_ret = (k == 0) ? 4'hf : 4'h0;
            settle();
            chk("t4_acc", 32'(u_bus.o_flit_accept), 32'b0001);
            step();
        end
        credit_ret = '0;
        chk("t4_noerr", 32'(credit_err), 32'h0);
`endif
        flit(0, 1'b1);
        settle();
        chk("t4_tail", 32'(u_bus.o_flit_accept), 32'b0001);
        step();
        clr_flits();

        // Reset in the middle of a VC2 packet.
        req(1, 2);
        step();
        chk("t6_grant", 32'(u_bus.o_grant), 32'b0010);
        chk("t6_busy", 32'(vc_busy), 32'b0100);
        u_bus.i_req[1] = 1'b0;
        flit(1, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr_flits();
        chk("t6_rst_grant", 32'(u_bus.o_grant), 32'h0);
        chk("t6_rst_busy", 32'(vc_busy), 32'h0);
        chk("t6_rst_owner", 32'(vc_owner), 32'h0);
        chk("t6_rst_err", 32'(credit_err), 32'h0);
        req(3, 2);
        step();
        chk("t6_regrant", 32'(u_bus.o_grant), 32'b1000);
        chk("t6_owner", 32'(vc_owner[2]), 32'd3);
        u_bus.i_req[3] = 1'b0;
`ifdef EXA_CROSB_VC_CREDIT_EN
        credit_ret[2] = 1'b1;
        step();
        credit_ret[2] = 1'b0;
        chk("t6_cred_full", 32'(credit_err), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
